ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the transmit side of the keyboard link, sharing the PS/2 CLK/DAT pair with the keyboard receiver.
- Sends one command byte to the keyboard (e.g. 0xED LED set, 0xFF reset) using open-drain line control.
- Reports completion, or failure on NACK or timeout, to the game-control logic.

---
 rtl/ps2_host_tx.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter.
//
// Sends one command byte to the keyboard over the shared open-drain PS/2
// CLK/DAT pair. The sequence is: inhibit the clock, drive the start bit,
// release the clock, then shift out 8 data bits, odd parity and stop bit on
// the device-generated clock. Finally the device's ACK bit is sampled and
// completion or failure is reported.
//
// Ports:
//   CLK        in   system clock
//   RESET      in   synchronous active-high reset
//   TX_DAT     in   [7:0] command byte, sampled when TX_REQ is accepted
//   TX_REQ     in   transfer request, accepted only while idle
//   TX_BUSY    out  high from the cycle after acceptance until back in IDLE
//   TX_DONE    out  one-cycle pulse: byte acknowledged and bus idle
//   TX_ERR     out  one-cycle pulse: NACK or watchdog timeout
//   PS_CLK     in   raw PS/2 clock line (asynchronous)
//   PS_DAT     in   raw PS/2 data line (asynchronous)
//   PS_CLK_OE  out  1 = pull PS_CLK low, 0 = release
//   PS_DAT_OE  out  1 = pull PS_DAT low, 0 = release
//
// Build option:
//   PS2_TX_RETRY_EN  when defined, the first NACK/timeout of a transfer
//                    silently re-sends the latched byte. Only a second
//                    consecutive failure pulses TX_ERR.

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES    = 5000,
  parameter int START_HOLD_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 750000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DAT,
  input  logic       TX_REQ,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  input  logic       PS_CLK,
  input  logic       PS_DAT,
  output logic       PS_CLK_OE,
  output logic       PS_DAT_OE
);

  // One shared counter serves the inhibit, start-hold and watchdog phases.
  // It is therefore sized for the largest of the three limits.
  localparam int MAX_A   = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(START_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE,
    ERR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          datOe_q, datOe_d;
  logic          done_q, done_d;

  logic psClkMeta_q, sPSCLK_q, sPSCLKD1_q;
  logic psDatMeta_q, sPSDAT_q;
  logic negPSCLK;
  logic wdogExpired;
  logic failNow;

`ifdef PS2_TX_RETRY_EN
  logic [7:0] byte_q, byte_d;
  logic       retry_q, retry_d;
`endif

  // Two-flop synchronizers for the raw bus lines, plus one extra clock stage
  // for falling-edge detection. They reset to the idle (pulled-up) level, so
  // leaving reset never fakes a falling edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      psClkMeta_q <= 1'b1;
      sPSCLK_q    <= 1'b1;
      sPSCLKD1_q  <= 1'b1;
      psDatMeta_q <= 1'b1;
      sPSDAT_q    <= 1'b1;
    end else begin
      psClkMeta_q <= PS_CLK;
      sPSCLK_q    <= psClkMeta_q;
      sPSCLKD1_q  <= sPSCLK_q;
      psDatMeta_q <= PS_DAT;
      sPSDAT_q    <= psDatMeta_q;
    end
  end

  assign negPSCLK    = ~sPSCLK_q & sPSCLKD1_q;
  assign wdogExpired = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      datOe_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      byte_q   <= '0;
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      datOe_q  <= datOe_d;
      done_q   <= done_d;
`ifdef PS2_TX_RETRY_EN
      byte_q   <= byte_d;
      retry_q  <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    datOe_d  = datOe_q;
    done_d   = 1'b0;
    failNow  = 1'b0;
`ifdef PS2_TX_RETRY_EN
    byte_d   = byte_q;
    retry_d  = retry_q;
`endif

    case (state_q)
      IDLE: begin
        datOe_d = 1'b0;
        cnt_d   = '0;
`ifdef PS2_TX_RETRY_EN
        retry_d = 1'b0;
`endif
        // A request that coincides with the DONE pulse is ignored, so the
        // requester always observes a completed handshake first.
        if (TX_REQ && !done_q) begin
          shift_d = {1'b1, ~^TX_DAT, TX_DAT};
`ifdef PS2_TX_RETRY_EN
          byte_d  = TX_DAT;
`endif
          state_d = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d   = '0;
          datOe_d = 1'b1;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      START: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d    = '0;
          bitCnt_d = '0;
          state_d  = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // The device samples on its rising edge, so the next bit is presented
      // right after each falling edge. The start bit is already on the line.
      SEND: begin
        if (negPSCLK) begin
          datOe_d  = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          bitCnt_d = bitCnt_q + 4'd1;
          cnt_d    = '0;
          if (bitCnt_q == 4'd9) begin
            state_d = ACK;
          end
        end else if (wdogExpired) begin
          failNow = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ACK: begin
        if (negPSCLK) begin
          cnt_d = '0;
          if (sPSDAT_q) begin
            failNow = 1'b1;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else if (wdogExpired) begin
          failNow = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (sPSCLK_q && sPSDAT_q) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (negPSCLK) begin
          cnt_d = '0;
        end else if (wdogExpired) begin
          failNow = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ERR: begin
        datOe_d = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Any failure releases the data line at once. A timeout may strike
    // while a 0 bit is still being driven.
    if (failNow) begin
      cnt_d   = '0;
      datOe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        shift_d = {1'b1, ~^byte_q, byte_q};
        state_d = INHIBIT;
      end else begin
        state_d = ERR;
      end
`else
      state_d = ERR;
`endif
    end
  end

  assign TX_BUSY   = (state_q != IDLE);
  assign TX_DONE   = done_q;
  assign TX_ERR    = (state_q == ERR);
  assign PS_CLK_OE = (state_q == INHIBIT) || (state_q == START);
  assign PS_DAT_OE = datOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx.
//
// Models the open-drain bus and a simple keyboard. The keyboard samples the
// start bit when the host releases the clock. It then generates ten clock
// pulses, sampling data on each rising edge, and clocks in an ACK bit of a
// chosen value. Short timing parameters keep the run small.

module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int HOLD = 2;
  localparam int TMO  = 300;
  localparam int H    = 15;

`ifdef PS2_TX_RETRY_EN
  localparam int EXP_TMO = 2 * TMO + INH + HOLD;
`else
  localparam int EXP_TMO = TMO;
`endif

  logic       CLK;
  logic       RESET;
  logic [7:0] TX_DAT;
  logic       TX_REQ;
  logic       TX_BUSY;
  logic       TX_DONE;
  logic       TX_ERR;
  logic       PS_CLK_OE;
  logic       PS_DAT_OE;
  logic       devClkLow;
  logic       devDatLow;
  wire        psClkLine = !(PS_CLK_OE || devClkLow);
  wire        psDatLine = !(PS_DAT_OE || devDatLow);

  int compareCount  = 0;
  int mismatchCount = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int bothCnt = 0;
  int inhibitEntries = 0;
  int doneBase = 0;
  int errBase = 0;
  logic       busyAtDone = 1'b0;
  logic [1:0] oeAtErr = 2'b00;
  logic       clkOePrev = 1'b0;

  typedef struct {
    logic [7:0]  dat;
    bit          ack;
    logic [10:0] expBits;
    int          expDone;
    int          expErr;
  } vec_t;

  vec_t vecs[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .TX_DAT(TX_DAT),
    .TX_REQ(TX_REQ),
    .TX_BUSY(TX_BUSY),
    .TX_DONE(TX_DONE),
    .TX_ERR(TX_ERR),
    .PS_CLK(psClkLine),
    .PS_DAT(psDatLine),
    .PS_CLK_OE(PS_CLK_OE),
    .PS_DAT_OE(PS_DAT_OE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse and phase bookkeeping, sampled away from the active edge.
  always @(negedge CLK) begin
    if (TX_DONE) begin
      doneCnt++;
      busyAtDone = TX_BUSY;
    end
    if (TX_ERR) begin
      errCnt++;
      oeAtErr = {PS_CLK_OE, PS_DAT_OE};
    end
    if (TX_DONE && TX_ERR) bothCnt++;
    if (PS_CLK_OE && !clkOePrev) inhibitEntries++;
    clkOePrev = PS_CLK_OE;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, required finish before 2000000 ns");
    $fatal(1, "[TB] global timeout");
  end

  function automatic vec_t mkVec(logic [7:0] d, bit a, logic [10:0] e, int dn, int er);
    vec_t v;
    v.dat = d;
    v.ack = a;
    v.expBits = e;
    v.expDone = dn;
    v.expErr = er;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues a one-cycle request. Returns on the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] d);
    TX_DAT = d;
    TX_REQ = 1'b1;
    @(negedge CLK);
    TX_REQ = 1'b0;
  endtask

  // Measures the inhibit and start-hold phases and returns on the first
  // cycle with the clock released. Optionally pokes a request mid-inhibit.
  task automatic waitStart(output int inh, output int hold, output logic sb,
                           input bit poke, input logic [7:0] pokeDat);
    int n = 0;
    while (!PS_CLK_OE && n < 200) begin
      @(negedge CLK);
      n++;
    end
    inh = 0;
    while (PS_CLK_OE && !PS_DAT_OE && inh < 4 * INH) begin
      if (poke && inh == 3) begin
        TX_REQ = 1'b1;
        TX_DAT = pokeDat;
      end else if (inh == 4) begin
        TX_REQ = 1'b0;
      end
      inh++;
      @(negedge CLK);
    end
    TX_REQ = 1'b0;
    hold = 0;
    while (PS_CLK_OE && PS_DAT_OE && hold < 100) begin
      hold++;
      @(negedge CLK);
    end
    sb = psDatLine;
  endtask

  // Keyboard side: ten clock pulses sampling on rising edges, then an ACK bit.
  task automatic deviceFrame(input bit ackVal, output logic [10:0] bits);
    bits = '0;
    repeat (10) @(negedge CLK);
    for (int i = 1; i <= 10; i++) begin
      devClkLow = 1'b1;
      repeat (H) @(negedge CLK);
      devClkLow = 1'b0;
      bits[i] = psDatLine;
      repeat (H) @(negedge CLK);
    end
    devDatLow = !ackVal;
    repeat (4) @(negedge CLK);
    devClkLow = 1'b1;
    repeat (H) @(negedge CLK);
    devClkLow = 1'b0;
    repeat (2) @(negedge CLK);
    devDatLow = 1'b0;
  endtask

  task automatic waitOutcome();
    int n = 0;
    while (!TX_DONE && errCnt == errBase && n < 400) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("outcomeSeen", 32'(n < 400), 32'd1);
  endtask

  task automatic settle(input int expDone, input int expErr);
    repeat (4) @(negedge CLK);
    checkOutput("donePulses", doneCnt - doneBase, expDone);
    checkOutput("errPulses", errCnt - errBase, expErr);
    if (expDone != 0) checkOutput("busyWithDone", 32'(busyAtDone), 32'd0);
    if (expErr != 0) checkOutput("linesAtErr", 32'(oeAtErr), 32'd0);
    checkOutput("idleAfter", {TX_BUSY, PS_CLK_OE, PS_DAT_OE}, 32'd0);
  endtask

  task automatic runFrame(input vec_t v);
    int inh, hold;
    logic sb;
    logic [10:0] bits;
    checkOutput("busyAfterReq", 32'(TX_BUSY), 32'd1);
    waitStart(inh, hold, sb, 1'b1, ~v.dat);
    checkOutput("inhibitLen", inh, INH);
    checkOutput("holdLen", hold, HOLD);
    deviceFrame(v.ack, bits);
    bits[0] = sb;
    checkOutput("frameBits", 32'(bits), 32'(v.expBits));
  endtask

  task automatic runVector(input vec_t v);
    doneBase = doneCnt;
    errBase = errCnt;
    applyStimulus(v.dat);
    runFrame(v);
    waitOutcome();
    checkOutput("doneFlag", 32'(TX_DONE), v.expDone);
    settle(v.expDone, v.expErr);
  endtask

  initial begin
    int inh, hold, n;
    logic sb;
    logic [10:0] bits;

    vecs.push_back(mkVec(8'hED, 1'b0, 11'b11111011010, 1, 0));
    vecs.push_back(mkVec(8'h07, 1'b0, 11'b10000001110, 1, 0));
    vecs.push_back(mkVec(8'h00, 1'b0, 11'b11000000000, 1, 0));
`ifndef PS2_TX_RETRY_EN
    vecs.push_back(mkVec(8'hA5, 1'b1, 11'b11101001010, 0, 1));
`endif

    RESET = 1'b1;
    TX_REQ = 1'b0;
    TX_DAT = 8'h00;
    devClkLow = 1'b0;
    devDatLow = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("resetOutputs", {TX_BUSY, TX_DONE, TX_ERR, PS_CLK_OE, PS_DAT_OE}, 32'd0);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("idleAfterReset", {TX_BUSY, TX_DONE, TX_ERR, PS_CLK_OE, PS_DAT_OE}, 32'd0);

    foreach (vecs[i]) begin
      $display("[TB] vector %0d: byte 0x%02h ack %0d", i, vecs[i].dat, vecs[i].ack);
      runVector(vecs[i]);
    end

    // A request held across the DONE cycle is taken one cycle later.
    $display("[TB] request coinciding with DONE");
    doneBase = doneCnt;
    errBase = errCnt;
    applyStimulus(8'h07);
    runFrame(mkVec(8'h07, 1'b0, 11'b10000001110, 1, 0));
    waitOutcome();
    checkOutput("doneSeen", 32'(TX_DONE), 32'd1);
    TX_DAT = 8'h00;
    TX_REQ = 1'b1;
    @(negedge CLK);
    checkOutput("reqWithDoneIgnored", 32'(TX_BUSY), 32'd0);
    @(negedge CLK);
    TX_REQ = 1'b0;
    doneBase = doneCnt;
    errBase = errCnt;
    runFrame(mkVec(8'h00, 1'b0, 11'b11000000000, 1, 0));
    waitOutcome();
    settle(1, 0);

    // Device never clocks after the clock release.
    $display("[TB] silent device timeout");
    doneBase = doneCnt;
    errBase = errCnt;
    applyStimulus(8'h3C);
    waitStart(inh, hold, sb, 1'b0, 8'h00);
    n = 0;
    while (!TX_ERR && n < EXP_TMO + 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("timeoutCycles", n, EXP_TMO);
    checkOutput("timeoutLines", {PS_CLK_OE, PS_DAT_OE}, 32'd0);
    settle(0, 1);

    // Reset in the middle of SEND, after four bits.
    $display("[TB] reset mid-frame");
    applyStimulus(8'h55);
    waitStart(inh, hold, sb, 1'b0, 8'h00);
    repeat (10) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      devClkLow = 1'b1;
      repeat (H) @(negedge CLK);
      devClkLow = 1'b0;
      repeat (H) @(negedge CLK);
    end
    checkOutput("datDrivenBeforeReset", 32'(PS_DAT_OE), 32'd1);
    doneBase = doneCnt;
    errBase = errCnt;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checkOutput("afterMidReset", {TX_BUSY, TX_DONE, TX_ERR, PS_CLK_OE, PS_DAT_OE}, 32'd0);
    repeat (10) @(negedge CLK);
    checkOutput("noPulsesAfterReset", (doneCnt - doneBase) + (errCnt - errBase), 32'd0);
    runVector(mkVec(8'hFF, 1'b0, 11'b11111111110, 1, 0));

`ifdef PS2_TX_RETRY_EN
    begin
      int entryBase;
      $display("[TB] retry: NACK then ACK");
      doneBase = doneCnt;
      errBase = errCnt;
      entryBase = inhibitEntries;
      applyStimulus(8'h5A);
      waitStart(inh, hold, sb, 1'b0, 8'h00);
      deviceFrame(1'b1, bits);
      bits[0] = sb;
      checkOutput("retryFrame1", 32'(bits), 32'(11'b11010110100));
      checkOutput("busyDuringRetry", 32'(TX_BUSY), 32'd1);
      checkOutput("noErrOnFirstNack", errCnt - errBase, 32'd0);
      waitStart(inh, hold, sb, 1'b0, 8'h00);
      deviceFrame(1'b0, bits);
      bits[0] = sb;
      checkOutput("retryFrame2", 32'(bits), 32'(11'b11010110100));
      waitOutcome();
      settle(1, 0);
      checkOutput("inhibitPhasesAck", inhibitEntries - entryBase, 32'd2);

      $display("[TB] retry: two NACKs");
      doneBase = doneCnt;
      errBase = errCnt;
      entryBase = inhibitEntries;
      applyStimulus(8'h5A);
      waitStart(inh, hold, sb, 1'b0, 8'h00);
      deviceFrame(1'b1, bits);
      waitStart(inh, hold, sb, 1'b0, 8'h00);
      deviceFrame(1'b1, bits);
      waitOutcome();
      settle(0, 1);
      checkOutput("inhibitPhasesNack", inhibitEntries - entryBase, 32'd2);
    end
`endif

    checkOutput("doneErrTogether", bothCnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
